// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: EX next-PC ops and fetch FSM states.
package pc_sequencer_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  typedef enum logic [1:0] {
    PCS_IDLE  = 2'd0,
    PCS_REQ   = 2'd1,
    PCS_HOLD  = 2'd2,
    PCS_DRAIN = 2'd3
  } pcs_state_e;

  function automatic logic is_redirect(input logic [2:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JALR);
  endfunction

endpackage

// File: rtl/pc_sequencer_skid_buf.sv
// One-entry instruction+PC holding register used while IF/ID is stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_load,
  input  logic        i_pop,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_vld,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_vld;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // Clear (redirect) wins over a same-cycle load or pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld   <= 1'b0;
      r_instr <= 32'd0;
      r_pc    <= 32'd0;
    end else if (i_clear) begin
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_vld   <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_pop) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld   = r_vld;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: sequences imem req/ack fetches, applies EX redirects,
// parks one instruction across IF stalls and drops wrong-path returns.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       npc_op,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_aluout,
  input  logic             stall_if,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  pcs_state_e       r_state;
  logic [31:0]      r_pc;
  logic             r_misalign;
  logic [CNT_W-1:0] r_cnt;

  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] w_target_al;
  logic        w_ack_req;
  logic        w_direct;
  logic        w_load;
  logic        w_pop;
  logic        w_buf_vld;
  logic [31:0] w_buf_instr;
  logic [31:0] w_buf_pc;

  assign w_redir     = is_redirect(npc_op);
  assign w_target    = (npc_op == NPC_JALR) ? (ex_aluout & ~32'd1) : (ex_pc + ex_imm);
  assign w_target_al = {w_target[31:2], 2'b00};

  // An acked fetch goes straight to IF/ID only when nothing is stalled or parked.
  assign w_ack_req = (r_state == PCS_REQ) && imem_ack;
  assign w_direct  = !w_redir && w_ack_req && !stall_if && !w_buf_vld;
  assign w_load    = !w_redir && w_ack_req && !w_direct;
  assign w_pop     = !w_redir && (r_state == PCS_HOLD) && !stall_if;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_load),
    .i_pop   (w_pop),
    .i_clear (w_redir),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_vld   (w_buf_vld),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= PCS_IDLE;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_misalign <= w_redir && (w_target[1:0] != 2'b00);
      if (w_redir && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
      case (r_state)
        PCS_IDLE: begin
          if (w_redir) r_pc <= w_target_al;
          r_state <= PCS_REQ;
        end
        PCS_REQ: begin
          if (w_redir) begin
            r_pc    <= w_target_al;
            r_state <= imem_ack ? PCS_REQ : PCS_DRAIN;
          end else if (imem_ack) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= w_load ? PCS_HOLD : PCS_REQ;
          end
        end
        PCS_HOLD: begin
          if (w_redir) begin
            r_pc    <= w_target_al;
            r_state <= PCS_REQ;
          end else if (!stall_if) begin
            r_state <= PCS_REQ;
          end
        end
        PCS_DRAIN: begin
          // The stale return is swallowed here; pc already tracks the newest target.
          if (w_redir) r_pc <= w_target_al;
          if (imem_ack) r_state <= PCS_REQ;
        end
        default: r_state <= PCS_IDLE;
      endcase
    end
  end

  always_comb begin
    if_instr = 32'd0;
    if_pc    = 32'd0;
    if (w_direct) begin
      if_instr = imem_rdata;
      if_pc    = r_pc;
    end else if (w_pop) begin
      if_instr = w_buf_instr;
      if_pc    = w_buf_pc;
    end
  end

  assign if_valid     = w_direct || w_pop;
  assign imem_req     = (r_state == PCS_REQ);
  assign imem_addr    = r_pc;
  assign flush_ifid   = w_redir;
  assign flush_idex   = w_redir;
  assign misalign_err = r_misalign;
  assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, stall buffering, redirects,
// drain of wrong-path returns, counter saturation and asynchronous reset.
module tb_pc_sequencer;

  localparam logic [2:0]  OP_PLUS4  = 3'b000;
  localparam logic [2:0]  OP_BRANCH = 3'b001;
  localparam logic [2:0]  OP_JUMP   = 3'b010;
  localparam logic [2:0]  OP_JALR   = 3'b100;
  localparam logic [31:0] SALT      = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  npc_op;
  logic [31:0] ex_pc, ex_imm, ex_aluout;
  logic        stall_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        flush_ifid, flush_idex, misalign_err;
  logic [1:0]  redirect_cnt;

  logic ack_auto, ack_man;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Memory model: instruction word is the address xor a fixed salt.
  assign imem_ack   = ack_auto ? imem_req : ack_man;
  assign imem_rdata = imem_addr ^ SALT;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .npc_op       (npc_op),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_aluout    (ex_aluout),
    .stall_if     (stall_if),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .misalign_err (misalign_err),
    .redirect_cnt (redirect_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; npc_op = OP_PLUS4; ex_pc = 0; ex_imm = 0; ex_aluout = 0;
    stall_if = 1'b0; ack_auto = 1'b1; ack_man = 1'b0;
    #2;
    chk("rst_req",    {31'd0, imem_req},     0);
    chk("rst_valid",  {31'd0, if_valid},     0);
    chk("rst_instr",  if_instr,              0);
    chk("rst_ifpc",   if_pc,                 0);
    chk("rst_cnt",    {30'd0, redirect_cnt}, 0);
    chk("rst_flush",  {30'd0, flush_ifid, flush_idex}, 0);
    chk("rst_misal",  {31'd0, misalign_err}, 0);
    tick();
    rstn = 1'b1;
    #2;
    chk("idle_req",   {31'd0, imem_req},     0);
    chk("idle_valid", {31'd0, if_valid},     0);
    tick();

    // Back-to-back fetch with ack tied to req.
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("seq_req",   {31'd0, imem_req}, 1);
      chk("seq_addr",  imem_addr, 32'(4 * i));
      chk("seq_valid", {31'd0, if_valid}, 1);
      chk("seq_ifpc",  if_pc, 32'(4 * i));
      chk("seq_instr", if_instr, 32'(4 * i) ^ SALT);
      tick();
    end

    // Stall for three cycles; the ack on the first is parked.
    stall_if = 1'b1;
    #2;
    chk("stl0_valid", {31'd0, if_valid}, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("stl_req",   {31'd0, imem_req}, 0);
      chk("stl_valid", {31'd0, if_valid}, 0);
      tick();
    end
    stall_if = 1'b0;
    #2;
    chk("unstl_valid", {31'd0, if_valid}, 1);
    chk("unstl_ifpc",  if_pc, 32'h10);
    chk("unstl_instr", if_instr, 32'h10 ^ SALT);
    chk("unstl_req",   {31'd0, imem_req}, 0);
    tick();
    #2;
    chk("resume_addr",  imem_addr, 32'h14);
    chk("resume_valid", {31'd0, if_valid}, 1);
    chk("resume_ifpc",  if_pc, 32'h14);
    tick();

    // Branch with nothing outstanding (IDLE after reset).
    do_reset();
    npc_op = OP_BRANCH; ex_pc = 32'h100; ex_imm = 32'h20;
    #2;
    chk("br_flush_ifid", {31'd0, flush_ifid}, 1);
    chk("br_flush_idex", {31'd0, flush_idex}, 1);
    chk("br_req",        {31'd0, imem_req}, 0);
    tick();
    npc_op = OP_PLUS4;
    #2;
    chk("br_addr",  imem_addr, 32'h120);
    chk("br_cnt",   {30'd0, redirect_cnt}, 1);
    chk("br_misal", {31'd0, misalign_err}, 0);
    chk("br_flush_off", {31'd0, flush_ifid}, 0);
    chk("br_ifpc",  if_pc, 32'h120);
    tick();

    // JALR to 0x203 while a 3-cycle fetch of 0x40 is outstanding.
    ack_auto = 1'b0; ack_man = 1'b0;
    do_reset();
    npc_op = OP_JUMP; ex_pc = 32'h40; ex_imm = 32'h0;
    tick();
    npc_op = OP_PLUS4;
    #2;
    chk("lat_req",   {31'd0, imem_req}, 1);
    chk("lat_addr",  imem_addr, 32'h40);
    chk("lat_valid", {31'd0, if_valid}, 0);
    tick();
    npc_op = OP_JALR; ex_aluout = 32'h203;
    #2;
    chk("jalr_flush", {31'd0, flush_idex}, 1);
    chk("jalr_valid", {31'd0, if_valid}, 0);
    tick();
    npc_op = OP_PLUS4; ack_man = 1'b1;
    #2;
    chk("drain_req",   {31'd0, imem_req}, 0);
    chk("drain_misal", {31'd0, misalign_err}, 1);
    chk("drain_cnt",   {30'd0, redirect_cnt}, 2);
    chk("drain_valid", {31'd0, if_valid}, 0);
    tick();
    ack_man = 1'b0;
    #2;
    chk("jalr_req",   {31'd0, imem_req}, 1);
    chk("jalr_addr",  imem_addr, 32'h200);
    chk("jalr_misal", {31'd0, misalign_err}, 0);
    tick();

    // Redirect to 0x80 in the ack cycle.
    ack_man = 1'b1; npc_op = OP_JUMP; ex_pc = 32'h80; ex_imm = 32'h0;
    #2;
    chk("rack_valid", {31'd0, if_valid}, 0);
    chk("rack_flush", {31'd0, flush_ifid}, 1);
    tick();
    ack_man = 1'b0; npc_op = OP_PLUS4;
    #2;
    chk("rack_addr",  imem_addr, 32'h80);
    chk("rack_req",   {31'd0, imem_req}, 1);
    chk("rack_nodat", {31'd0, if_valid}, 0);
    chk("rack_cnt",   {30'd0, redirect_cnt}, 3);
    tick();
    ack_man = 1'b1;
    #2;
    chk("rack_fetch_valid", {31'd0, if_valid}, 1);
    chk("rack_fetch_ifpc",  if_pc, 32'h80);
    tick();

    // Two more redirects: counter stays saturated, second one lands in DRAIN.
    ack_man = 1'b0; npc_op = OP_JUMP; ex_pc = 32'h0; ex_imm = 32'h0;
    tick();
    tick();
    npc_op = OP_PLUS4;
    #2;
    chk("sat_cnt", {30'd0, redirect_cnt}, 3);
    chk("sat_req", {31'd0, imem_req}, 0);
    ack_man = 1'b1;
    #1;
    chk("sat_drop", {31'd0, if_valid}, 0);
    tick();
    #2;
    chk("sat_addr", imem_addr, 32'h0);
    tick();
    ack_man = 1'b0;

    // Asynchronous reset while a request to 0x4 is pending.
    #2;
    chk("pre_rst_addr", imem_addr, 32'h4);
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_req",  {31'd0, imem_req}, 0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_cnt",  {30'd0, redirect_cnt}, 0);
    chk("arst_ifpc", if_pc, 32'h0);
    tick();
    rstn = 1'b1; ack_man = 1'b1;
    #2;
    chk("idle_ack_valid", {31'd0, if_valid}, 0);
    tick();
    ack_man = 1'b0;
    #2;
    chk("post_rst_req",   {31'd0, imem_req}, 1);
    chk("post_rst_addr",  imem_addr, 32'h0);
    chk("post_rst_valid", {31'd0, if_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
